value_change_scheduler: RTL and testbench

- Transmit-side counterpart to the value-change detectors used in our event-control monitors.
- Accepts (value, hold-delay) entries over a valid/ready interface into a small FIFO.
- Drives value_out with each entry after its programmed delay.
- Flags every update, and separately flags only the updates that actually change the value, so downstream change-sensitive logic gets deterministic, cycle-accurate stimulus.

---
 rtl/value_change_scheduler.sv | 178 +++++++++++++++++
 tb/tb_value_change_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/value_change_scheduler.sv
// Delayed value scheduler: (value, delay) entries are queued in a small FIFO
// and applied to value_out one at a time, with update and change strobes.
module value_change_scheduler #(
  parameter int                DATA_W   = 8,
  parameter int                DLY_W    = 8,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_value,
  input  logic [DLY_W-1:0]           in_delay,
  input  logic                       pause,
  output logic [DATA_W-1:0]          value_out,
  output logic                       upd_strobe,
  output logic                       chg_strobe,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] val_mem_q [DEPTH];
  logic [DATA_W-1:0] val_mem_d [DEPTH];
  logic [DLY_W-1:0]  dly_mem_q [DEPTH];
  logic [DLY_W-1:0]  dly_mem_d [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_val_q, hold_val_d;
  logic [DATA_W-1:0] value_out_q, value_out_d;
  logic              upd_q, upd_d;
  logic              chg_q, chg_d;

  logic push_s;
  logic pop_s;
  logic apply_s;
  logic fifo_empty_s;
  logic fifo_full_s;

  assign fifo_empty_s = (count_q == {LVL_W{1'b0}});
  assign fifo_full_s  = (count_q == LVL_W'(DEPTH));
  assign push_s       = in_valid && !fifo_full_s;
  // Pop is decided from registered occupancy, so a fresh push waits one edge.
  assign pop_s        = (state_q == IDLE) && !fifo_empty_s;
  assign apply_s      = (state_q == HOLD) && !pause && (cnt_q == {DLY_W{1'b0}});

  assign in_ready   = !fifo_full_s;
  assign level      = count_q;
  assign busy       = (state_q != IDLE) || !fifo_empty_s;
  assign value_out  = value_out_q;
  assign upd_strobe = upd_q;
  assign chg_strobe = chg_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop_s) state_d = HOLD;
        else       state_d = IDLE;
      end
      HOLD: begin
        if (apply_s) state_d = IDLE;
        else         state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping, delay countdown and apply outputs.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (wr_ptr_q == PTR_W'(i))) begin
        val_mem_d[i] = in_value;
        dly_mem_d[i] = in_delay;
      end else begin
        val_mem_d[i] = val_mem_q[i];
        dly_mem_d[i] = dly_mem_q[i];
      end
    end

    if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else        wr_ptr_d = wr_ptr_q;

    if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else       rd_ptr_d = rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    cnt_d       = cnt_q;
    hold_val_d  = hold_val_q;
    value_out_d = value_out_q;
    upd_d       = 1'b0;
    chg_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          cnt_d      = dly_mem_q[rd_ptr_q];
          hold_val_d = val_mem_q[rd_ptr_q];
        end else begin
          cnt_d      = cnt_q;
        end
      end
      HOLD: begin
        if (pause) begin
          cnt_d = cnt_q;
        end else if (cnt_q != {DLY_W{1'b0}}) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else begin
          value_out_d = hold_val_q;
          upd_d       = 1'b1;
          chg_d       = (hold_val_q != value_out_q);
        end
      end
      default: begin
        cnt_d = {DLY_W{1'b0}};
      end
    endcase
  end

  // Datapath registers; reset drops any queued or in-flight entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_mem_q[i] <= {DATA_W{1'b0}};
        dly_mem_q[i] <= {DLY_W{1'b0}};
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {LVL_W{1'b0}};
      cnt_q       <= {DLY_W{1'b0}};
      hold_val_q  <= {DATA_W{1'b0}};
      value_out_q <= INIT_VAL;
      upd_q       <= 1'b0;
      chg_q       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        val_mem_q[i] <= val_mem_d[i];
        dly_mem_q[i] <= dly_mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      hold_val_q  <= hold_val_d;
      value_out_q <= value_out_d;
      upd_q       <= upd_d;
      chg_q       <= chg_d;
    end
  end

endmodule

// File: tb/tb_value_change_scheduler.sv
// Scoreboard bench for value_change_scheduler: stimulus queues expected
// applies (value, change flag, edge index); a negedge monitor checks them.
module tb_value_change_scheduler;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_value;
  logic [7:0] in_delay;
  logic       pause;
  logic [7:0] value_out;
  logic       upd_strobe;
  logic       chg_strobe;
  logic       busy;
  logic [2:0] level;

  value_change_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_delay   (in_delay),
    .pause      (pause),
    .value_out  (value_out),
    .upd_strobe (upd_strobe),
    .chg_strobe (chg_strobe),
    .busy       (busy),
    .level      (level)
  );

  typedef struct {
    int val;
    int chg;
    int at_edge;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   last_e = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every update strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (upd_strobe) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_upd: got value %0d at edge %0d, expected no update", value_out, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("apply_value", int'(value_out), e.val);
        chk("apply_chg", int'(chg_strobe), e.chg);
        chk("apply_edge", cyc, e.at_edge);
      end
    end else if (chg_strobe) begin
      compared++;
      mismatched++;
      $display("FAIL chg_without_upd: got chg_strobe=1 at edge %0d, expected 0", cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_apply(input int v, input int c, input int e);
    exp_t x;
    x.val = v;
    x.chg = c;
    x.at_edge = e;
    exp_q.push_back(x);
  endtask

  task automatic push(input logic [7:0] v, input logic [7:0] d);
    in_valid = 1'b1;
    in_value = v;
    in_delay = d;
    chk("push_ready", int'(in_ready), 1);
    step();
    last_e   = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending applies, expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
    chk("busy_after_drain", int'(busy), 0);
  endtask

  initial begin
    int e0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_value = 8'd0;
    in_delay = 8'd0;
    pause    = 1'b0;

    // 1: reset state
    repeat (3) step();
    rst = 1'b1;
    chk("rst_value", int'(value_out), 0);
    chk("rst_upd", int'(upd_strobe), 0);
    chk("rst_chg", int'(chg_strobe), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    step();

    // 2: single entry, delay 0
    push(8'd102, 8'd0);
    expect_apply(102, 1, last_e + 2);
    drain(20);

    // 3: equal-value reschedule then change
    push(8'd110, 8'd5);
    e0 = last_e;
    push(8'd110, 8'd3);
    push(8'd120, 8'd0);
    expect_apply(110, 1, e0 + 7);
    expect_apply(110, 0, e0 + 12);
    expect_apply(120, 1, e0 + 14);
    drain(40);
    chk("t3_value_held", int'(value_out), 120);

    // 4: fill the FIFO; sixth offer is held off
    push(8'd11, 8'd20);
    e0 = last_e;
    push(8'd12, 8'd20);
    push(8'd13, 8'd20);
    push(8'd14, 8'd20);
    push(8'd15, 8'd20);
    chk("t4_level_full", int'(level), 4);
    chk("t4_ready_low", int'(in_ready), 0);
    chk("t4_busy", int'(busy), 1);
    in_valid = 1'b1;
    in_value = 8'd16;
    in_delay = 8'd20;
    step();
    chk("t4_level_after_blocked", int'(level), 4);
    chk("t4_ready_still_low", int'(in_ready), 0);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_apply(11 + k, 1, e0 + 22 * (k + 1));
    end
    drain(200);
    chk("t4_level_empty", int'(level), 0);

    // 5: pause for 3 edges during HOLD
    push(8'd130, 8'd10);
    e0 = last_e;
    expect_apply(130, 1, e0 + 15);
    step();
    step();
    pause = 1'b1;
    repeat (3) step();
    pause = 1'b0;
    drain(40);

    // 6: reset in the middle of HOLD
    push(8'd50, 8'd20);
    push(8'd60, 8'd0);
    repeat (3) step();
    chk("t6_busy_before", int'(busy), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_value_init", int'(value_out), 0);
    chk("t6_level", int'(level), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ready", int'(in_ready), 1);
    repeat (30) step();
    chk("t6_value_quiet", int'(value_out), 0);
    chk("t6_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
